// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: 4-digit FND scan sequencer with dead time, leading-zero blanking and frame-aligned update.
// Latency: outputs registered, valid the cycle after the state edge; no backpressure, i_load always accepted (last write wins).
module fnd_scan_controller #(
  parameter int CLK_DIV    = 100000,
  parameter int SLOT_TICKS = 4,
  parameter int DEAD_TICKS = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  input  logic        i_load,
  output logic        o_pending,
  output logic [1:0]  o_digitPosion,
  output logic [3:0]  o_digitValue,
  output logic        o_dot,
  output logic        o_blank,
  output logic        o_frameDone
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(SLOT_TICKS) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] ON_END   = SW'(SLOT_TICKS - DEAD_TICKS);
  localparam logic [SW-1:0] SLOT_END = SW'(SLOT_TICKS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_DEAD = 2'd2} state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_pos;
  logic [15:0]   r_pend_val, r_sh_val;
  logic [3:0]    r_pend_dp, r_sh_dp;
  logic          r_pend_lzb, r_sh_lzb;
  logic          r_pending;
  logic [3:0]    r_digit_val;
  logic          r_dot, r_blank, r_frame_done;

  logic          w_tick;
  logic [SW-1:0] w_slot_inc;
  state_t        w_state_nxt;
  logic [DW-1:0] w_div_nxt;
  logic [SW-1:0] w_slot_nxt;
  logic [1:0]    w_pos_nxt;
  logic          w_wrap, w_apply;
  logic [15:0]   w_sh_val_nxt;
  logic [3:0]    w_sh_dp_nxt;
  logic          w_sh_lzb_nxt;
  logic [3:0]    w_nib;
  logic          w_lzb_blank;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_slot_inc = r_slot + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_slot_nxt  = r_slot;
    w_pos_nxt   = r_pos;
    w_wrap      = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_div_nxt   = '0;
      w_slot_nxt  = '0;
      w_pos_nxt   = 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ON;
          w_div_nxt   = '0;
          w_slot_nxt  = '0;
          w_pos_nxt   = 2'd0;
        end
        ST_ON: begin
          w_div_nxt = w_tick ? '0 : r_div + 1'b1;
          if (w_tick) begin
            w_slot_nxt = w_slot_inc;
            if (w_slot_inc == ON_END) w_state_nxt = ST_DEAD;
          end
        end
        ST_DEAD: begin
          w_div_nxt = w_tick ? '0 : r_div + 1'b1;
          if (w_tick) begin
            if (w_slot_inc == SLOT_END) begin
              w_slot_nxt  = '0;
              w_pos_nxt   = r_pos + 2'd1;
              w_state_nxt = ST_ON;
              w_wrap      = (r_pos == 2'd3);
            end else begin
              w_slot_nxt = w_slot_inc;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pending data only reaches the display at a frame wrap, or immediately while dark.
  assign w_apply      = r_pending && (w_wrap || (r_state == ST_IDLE));
  assign w_sh_val_nxt = w_apply ? r_pend_val : r_sh_val;
  assign w_sh_dp_nxt  = w_apply ? r_pend_dp  : r_sh_dp;
  assign w_sh_lzb_nxt = w_apply ? r_pend_lzb : r_sh_lzb;

  always_comb begin
    w_nib       = w_sh_val_nxt[3:0];
    w_lzb_blank = 1'b0;
    case (w_pos_nxt)
      2'd1: begin
        w_nib       = w_sh_val_nxt[7:4];
        w_lzb_blank = (w_sh_val_nxt[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib       = w_sh_val_nxt[11:8];
        w_lzb_blank = (w_sh_val_nxt[15:8] == 8'h00);
      end
      2'd3: begin
        w_nib       = w_sh_val_nxt[15:12];
        w_lzb_blank = (w_sh_val_nxt[15:12] == 4'h0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_slot       <= '0;
      r_pos        <= 2'd0;
      r_pend_val   <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_lzb   <= 1'b0;
      r_pending    <= 1'b0;
      r_sh_val     <= 16'h0000;
      r_sh_dp      <= 4'h0;
      r_sh_lzb     <= 1'b0;
      r_digit_val  <= 4'h0;
      r_dot        <= 1'b0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_slot       <= w_slot_nxt;
      r_pos        <= w_pos_nxt;
      r_sh_val     <= w_sh_val_nxt;
      r_sh_dp      <= w_sh_dp_nxt;
      r_sh_lzb     <= w_sh_lzb_nxt;
      if (i_load) begin
        r_pend_val <= i_value;
        r_pend_dp  <= i_dp;
        r_pend_lzb <= i_lzb;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending  <= 1'b0;
      end
      r_digit_val  <= w_nib;
      r_dot        <= w_sh_dp_nxt[w_pos_nxt];
      r_blank      <= (w_state_nxt != ST_ON) || (w_sh_lzb_nxt && w_lzb_blank);
      r_frame_done <= w_wrap;
    end
  end

  assign o_pending     = r_pending;
  assign o_digitPosion = r_pos;
  assign o_digitValue  = r_digit_val;
  assign o_dot         = r_dot;
  assign o_blank       = r_blank;
  assign o_frameDone   = r_frame_done;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller; expectations are queued with the cycle they are due and checked by a monitor.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n, en, load, lzb;
  logic [15:0] val;
  logic [3:0]  dp;
  logic        pend, dot, blank, fd;
  logic [1:0]  pos;
  logic [3:0]  dval;

  always #5 clk = ~clk;

  fnd_scan_controller #(.CLK_DIV(4), .SLOT_TICKS(4), .DEAD_TICKS(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_value(val), .i_dp(dp),
    .i_lzb(lzb), .i_load(load), .o_pending(pend), .o_digitPosion(pos),
    .o_digitValue(dval), .o_dot(dot), .o_blank(blank), .o_frameDone(fd)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] pk(input logic [1:0] p, input logic [3:0] v,
                                    input logic d, input logic b, input logic f, input logic pe);
    return {p, v, d, b, f, pe};
  endfunction

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got {pos,val,dot,blank,fd,pend}=%b_%h_%b%b%b%b expected %b_%h_%b%b%b%b",
               nm, cyc, act[9:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[9:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input int c, input string nm, input logic [1:0] p, input logic [3:0] v,
                      input logic d, input logic b, input logic f, input logic pe);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.exp  = pk(p, v, d, b, f, pe);
    q.push_back(e);
  endtask

  // Monitor: compares every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: expectation for cyc %0d seen at cyc %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, pk(pos, dval, dot, blank, fd, pend), e.exp);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z);
    val  = v;
    dp   = d;
    lzb  = z;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int b, s, f, g, h, r;

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; lzb = 1'b0; val = 16'h0; dp = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_state", pk(pos, dval, dot, blank, fd, pend), pk(2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Load 1234 while dark, then enable: 16-cycle slots, 12 lit + 4 dead.
    b = cyc;
    s = b + 3;
    push(b + 1, "idle_load_pending", 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(b + 2, "idle_load_applied", 2'd0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      logic [1:0] pp;
      logic [3:0] vv;
      pp = 2'(p);
      vv = 4'(4 - p);
      push(s + 16*p,      "s1_slot_start", pp, vv, 1'b0, 1'b0, 1'b0, 1'b0);
      push(s + 16*p + 11, "s1_last_on",    pp, vv, 1'b0, 1'b0, 1'b0, 1'b0);
      push(s + 16*p + 12, "s1_first_dead", pp, vv, 1'b0, 1'b1, 1'b0, 1'b0);
      push(s + 16*p + 15, "s1_last_dead",  pp, vv, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    push(s + 64, "s1_frame_done", 2'd0, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0);
    push(s + 65, "s1_fd_one_cycle", 2'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    do_load(16'h1234, 4'h0, 1'b0);
    goto(b + 2);
    en = 1'b1;

    // 00A0 with LZB and dot on digit 2, applied at the next wrap.
    goto(s + 65);
    f = s + 128;
    push(s + 66,  "s2_pending_set",   2'd0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    push(s + 127, "s2_pending_hold",  2'd3, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(f,       "s2_d0_zero_shown", 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(f + 16,  "s2_d1_A",          2'd1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    push(f + 28,  "s2_d1_dead",       2'd1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    push(f + 32,  "s2_d2_lzb_dot",    2'd2, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(f + 40,  "s2_d2_lzb_dot_mid",2'd2, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(f + 48,  "s2_d3_lzb",        2'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_load(16'h00A0, 4'b0100, 1'b1);

    // BEEF in slot 1, CAFE in slot 2: only CAFE ever reaches the display.
    g = f + 64;
    goto(g + 20);
    push(g + 21,  "s3_beef_pending",  2'd1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    push(g + 37,  "s3_cafe_pending",  2'd2, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    push(g + 63,  "s3_old_held",      2'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(g + 64,  "s3_cafe_d0",       2'd0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
    push(g + 80,  "s3_cafe_d1",       2'd1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    push(g + 96,  "s3_cafe_d2",       2'd2, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    push(g + 112, "s3_cafe_d3",       2'd3, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    do_load(16'hBEEF, 4'h0, 1'b0);
    goto(g + 36);
    do_load(16'hCAFE, 4'h0, 1'b0);

    // Drop enable mid-ON of digit 2, then re-enable.
    h = g + 128;
    r = h + 41;
    goto(g + 113);
    push(h + 37, "s4_idle_blank",     2'd0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
    push(h + 38, "s4_idle_no_fd",     2'd0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
    push(r,      "s4_restart_d0",     2'd0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    push(r + 11, "s4_restart_on",     2'd0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    push(r + 12, "s4_restart_dead",   2'd0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
    push(r + 16, "s4_restart_d1",     2'd1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    goto(h + 36);
    en = 1'b0;
    goto(h + 40);
    en = 1'b1;

    // Load landing on the wrap edge: old pending applied, new stays pending.
    goto(r + 20);
    push(r + 21,  "s6_first_pending", 2'd1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    push(r + 64,  "s6_wrap_applied",  2'd0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    push(r + 65,  "s6_still_pending", 2'd0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    push(r + 127, "s6_pending_hold",  2'd3, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1);
    push(r + 128, "s6_second_applied",2'd0, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
    do_load(16'h5678, 4'h0, 1'b0);
    goto(r + 63);
    do_load(16'h9ABC, 4'h0, 1'b0);

    // Async reset mid-DEAD with pending data.
    goto(r + 130);
    push(r + 131, "s5_pending_before_rst", 2'd0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1);
    do_load(16'h1111, 4'h0, 1'b0);
    goto(r + 141);
    #2 rst_n = 1'b0;
    #1 check("async_reset", pk(pos, dval, dot, blank, fd, pend), pk(2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    push(b + 1, "s5_pending_lost", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    goto(b + 3);

    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
